uart_rx_decoder: RTL and testbench



---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_rx_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state codes, parity modes and the bit-period
// divider calculation used by the receiver (and a future transmitter).
package uart_rx_pkg;

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD  = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;

  typedef logic [2:0] state_t;

  localparam state_t ST_WAIT_IDLE = 3'd0;
  localparam state_t ST_IDLE      = 3'd1;
  localparam state_t ST_START     = 3'd2;
  localparam state_t ST_DATA      = 3'd3;
  localparam state_t ST_PAR       = 3'd4;
  localparam state_t ST_STOP      = 3'd5;

  // Clock cycles per bit, rounded to nearest.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for decoded characters: the head entry is
// visible on o_rdata whenever o_empty is low.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_count;

endmodule

// File: rtl/uart_rx_decoder.sv
// UART receive decoder: line synchroniser, mid-bit sampling FSM, parity and
// framing checks, and an overrun-flagged FWFT buffer with a ready/valid drain.
module uart_rx_decoder
  import uart_rx_pkg::*;
#(
  parameter int CLK_HZ     = 31_250_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_i,
  output logic [DATA_BITS-1:0]        data_o,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        overrun_o,
  input  logic                        clr_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  // state        | meaning
  // WAIT_IDLE    | after reset or a framing error, wait for the line to go high
  // IDLE         | line idle, watching for a start edge
  // START        | half a bit in, confirm the start bit is still low
  // DATA         | sample DATA_BITS data bits, LSB first
  // PAR          | sample the parity bit
  // STOP         | sample STOP_BITS stop bits, then push the character

  localparam int     DIV       = div_calc(CLK_HZ, BAUD);
  localparam int     CW        = $clog2(DIV);
  localparam int     BW        = $clog2(DATA_BITS);
  localparam int     EW        = DATA_BITS + 2;
  localparam state_t ST_AFTER_DATA = (PARITY != 0) ? ST_PAR : ST_STOP;

  if (DIV < 4) begin : g_bad_div
    $error("uart_rx_decoder: DIV = %0d, must be at least 4", DIV);
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_rx_decoder: DATA_BITS must be 5..8");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_rx_decoder: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_decoder: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_decoder: FIFO_DEPTH must be a power of two >= 2");
  end

  logic                 r_sync1;
  logic                 r_sync2;
  logic [1:0]           r_warm;
  state_t               r_state;
  logic [CW-1:0]        r_cnt;
  logic [BW-1:0]        r_bitn;
  logic                 r_stopn;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_push;
  logic [EW-1:0]        r_push_data;
  logic                 r_overrun;

  logic                 w_rx_s;
  logic                 w_half;
  logic                 w_tick;
  logic                 w_par_x;
  logic                 w_par_err;
  logic                 w_ferr_next;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;
  logic [EW-1:0]        w_head;

  assign w_rx_s      = r_sync2;
  assign w_half      = (r_cnt == CW'(DIV / 2 - 1));
  assign w_tick      = (r_cnt == CW'(DIV - 1));
  assign w_par_x     = (^r_shift) ^ w_rx_s;
  assign w_par_err   = (PARITY == int'(PAR_ODD)) ? !w_par_x : w_par_x;
  assign w_ferr_next = r_ferr | !w_rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_warm  <= 2'b00;
    end else begin
      r_sync1 <= rx_i;
      r_sync2 <= r_sync1;
      r_warm  <= {r_warm[0], 1'b1};
    end
  end

  // r_warm holds WAIT_IDLE until the synchroniser carries real line samples
  // instead of its reset value, so a line held low at reset is never decoded.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_WAIT_IDLE;
      r_cnt       <= '0;
      r_bitn      <= '0;
      r_stopn     <= 1'b0;
      r_shift     <= '0;
      r_perr      <= 1'b0;
      r_ferr      <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= 1'b0;
      case (r_state)
        ST_WAIT_IDLE: begin
          if (r_warm[1] && w_rx_s) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!w_rx_s) begin
            r_state <= ST_START;
            r_cnt   <= '0;
          end
        end
        ST_START: begin
          if (w_half) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_DATA;
              r_bitn  <= '0;
              r_stopn <= 1'b0;
              r_perr  <= 1'b0;
              r_ferr  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            r_bitn  <= r_bitn + 1'b1;
            if (r_bitn == BW'(DATA_BITS - 1)) r_state <= ST_AFTER_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_PAR: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_perr  <= w_par_err;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt  <= '0;
            r_ferr <= w_ferr_next;
            if (r_stopn == 1'(STOP_BITS - 1)) begin
              r_push      <= 1'b1;
              r_push_data <= {w_ferr_next, r_perr, r_shift};
              r_stopn     <= 1'b0;
              r_state     <= w_ferr_next ? ST_WAIT_IDLE : ST_IDLE;
            end else begin
              r_stopn <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_WAIT_IDLE;
      endcase
    end
  end

  assign w_pop = valid_o && ready_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (r_push && w_full && !w_pop) begin
      r_overrun <= 1'b1;
    end else if (clr_i) begin
      r_overrun <= 1'b0;
    end
  end

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_push),
    .i_wdata (r_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );

  assign valid_o   = !w_empty;
  assign overrun_o = r_overrun;
  assign {frame_err_o, parity_err_o, data_o} = valid_o ? w_head : '0;

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Directed and randomised bench for uart_rx_decoder on three configurations:
// A = 8N1 DIV 16, B = 8E1 DIV 16, C = 5 bits odd parity 2 stop DIV 20 depth 4.
module tb_uart_rx_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rx_a, rx_b, rx_c;
  logic       ready_a, ready_b, ready_c;
  logic       clr_a, clr_b, clr_c;
  logic [7:0] data_a, data_b;
  logic [4:0] data_c;
  logic       fe_a, fe_b, fe_c, pe_a, pe_b, pe_c;
  logic       valid_a, valid_b, valid_c, ovr_a, ovr_b, ovr_c;
  logic [4:0] level_a, level_b;
  logic [2:0] level_c;

  uart_rx_decoder #(.CLK_HZ(1_600_000), .BAUD(100_000)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_a), .data_o(data_a), .frame_err_o(fe_a),
    .parity_err_o(pe_a), .valid_o(valid_a), .ready_i(ready_a), .overrun_o(ovr_a),
    .clr_i(clr_a), .level_o(level_a));

  uart_rx_decoder #(.CLK_HZ(1_600_000), .BAUD(100_000), .PARITY(2)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_b), .data_o(data_b), .frame_err_o(fe_b),
    .parity_err_o(pe_b), .valid_o(valid_b), .ready_i(ready_b), .overrun_o(ovr_b),
    .clr_i(clr_b), .level_o(level_b));

  uart_rx_decoder #(.CLK_HZ(2_000_000), .BAUD(100_000), .DATA_BITS(5), .PARITY(1),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .clk(clk), .rst_n(rst_n), .rx_i(rx_c), .data_o(data_c), .frame_err_o(fe_c),
    .parity_err_o(pe_c), .valid_o(valid_c), .ready_i(ready_c), .overrun_o(ovr_c),
    .clr_i(clr_c), .level_o(level_c));

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_a = -1;
  bit prev_va = 1'b0;
  bit rnd_ready = 1'b0;

  // Entries packed as {frame_err, parity_err, data zero-extended to 8 bits}.
  logic [9:0] exp_a[$], exp_b[$], exp_c[$];
  logic [9:0] got_a[$], got_b[$], got_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_a && ready_a) got_a.push_back({fe_a, pe_a, data_a});
    if (valid_b && ready_b) got_b.push_back({fe_b, pe_b, data_b});
    if (valid_c && ready_c) got_c.push_back({fe_c, pe_c, 3'b000, data_c});
    if (valid_a && !prev_va) rise_a = cyc;
    prev_va = valid_a;
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rnd_ready) begin
        ready_a = 1'($urandom_range(0, 1));
        ready_b = 1'($urandom_range(0, 1));
        ready_c = 1'($urandom_range(0, 1));
      end
    end
  end

  function automatic int cfg_div(input int inst);
    return (inst == 2) ? 20 : 16;
  endfunction
  function automatic int cfg_dbits(input int inst);
    return (inst == 2) ? 5 : 8;
  endfunction
  function automatic int cfg_par(input int inst);
    return (inst == 0) ? 0 : ((inst == 1) ? 2 : 1);
  endfunction
  function automatic int cfg_stop(input int inst);
    return (inst == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic line(input int inst, input logic v, input int cycles);
    set_rx(inst, v);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Drives one character and records what the receiver must deliver for it.
  task automatic send_frame(input int inst, input logic [7:0] data, input logic pbit,
                            input logic [1:0] stopv, input int tail, input bit push_exp);
    int div, db, pr, sb;
    logic [7:0] d;
    logic x, pe, fe;
    div = cfg_div(inst);
    db  = cfg_dbits(inst);
    pr  = cfg_par(inst);
    sb  = cfg_stop(inst);
    d   = data & 8'((1 << db) - 1);
    start_cyc = cyc;
    line(inst, 1'b0, div);
    for (int k = 0; k < db; k++) line(inst, d[k], div);
    if (pr != 0) line(inst, pbit, div);
    for (int k = 0; k < sb; k++) line(inst, stopv[k], div);
    if (tail > 0) line(inst, 1'b1, tail);
    x  = (^d) ^ pbit;
    pe = (pr == 1) ? !x : ((pr == 2) ? x : 1'b0);
    fe = !stopv[0] || (sb == 2 && !stopv[1]);
    if (push_exp) begin
      case (inst)
        0:       exp_a.push_back({fe, pe, d});
        1:       exp_b.push_back({fe, pe, d});
        default: exp_c.push_back({fe, pe, d});
      endcase
    end
  endtask

  task automatic check_drain(input int inst, input string tag);
    logic [9:0] e[$];
    logic [9:0] g[$];
    case (inst)
      0:       begin e = exp_a; g = got_a; exp_a.delete(); got_a.delete(); end
      1:       begin e = exp_b; g = got_b; exp_b.delete(); got_b.delete(); end
      default: begin e = exp_c; g = got_c; exp_c.delete(); got_c.delete(); end
    endcase
    chk({tag, " count"}, g.size(), e.size());
    for (int k = 0; k < e.size(); k++)
      chk($sformatf("%s entry %0d", tag, k), (k < g.size()) ? 32'(g[k]) : 32'hDEAD, 32'(e[k]));
  endtask

  initial begin
    logic [7:0] rd;
    int exp_lat;
    rst_n = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst valid_a", valid_a, 0);
    chk("rst data_a", data_a, 0);
    chk("rst fe_a", fe_a, 0);
    chk("rst pe_a", pe_a, 0);
    chk("rst ovr_a", ovr_a, 0);
    chk("rst level_a", level_a, 0);
    chk("rst level_c", level_c, 0);
    rst_n = 1'b1;
    line(0, 1'b1, 8);

    // Single clean character and output latency from the start edge
    rise_a = -1;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 32, 1'b1);
    exp_lat = 2 + 1 + 16 / 2 + (8 + 0 + 1) * 16 + 1;
    chk("a5 latency", rise_a - start_cyc, exp_lat);
    chk("a5 count", got_a.size(), 1);
    chk("a5 entry", got_a[0], 10'h0A5);
    chk("a5 level", level_a, 0);
    check_drain(0, "a5");

    // Even parity on B
    send_frame(1, 8'h07, 1'b0, 2'b11, 32, 1'b1);
    send_frame(1, 8'h07, 1'b1, 2'b11, 32, 1'b1);
    chk("par count", got_b.size(), 2);
    chk("par bad", got_b[0], 10'h107);
    chk("par good", got_b[1], 10'h007);
    check_drain(1, "par");

    // Framing error followed by a long break
    send_frame(0, 8'h3C, 1'b0, 2'b00, 0, 1'b1);
    line(0, 1'b0, 20 * 16);
    line(0, 1'b1, 32);
    chk("brk count", got_a.size(), 1);
    chk("brk entry", got_a[0], 10'h23C);
    send_frame(0, 8'h11, 1'b0, 2'b11, 32, 1'b1);
    chk("brk recover count", got_a.size(), 2);
    check_drain(0, "brk");

    // 5 data bits, odd parity, two stop bits on C
    send_frame(2, 8'h1F, 1'b0, 2'b11, 40, 1'b1);
    send_frame(2, 8'h1F, 1'b0, 2'b01, 40, 1'b1);
    chk("c5 good", got_c[0], 10'h01F);
    chk("c5 stop2", got_c[1], 10'h21F);
    check_drain(2, "c5");

    // Randomised characters with random drain back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rd = 8'($urandom);
      send_frame(0, rd, 1'b0, ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11, 32, 1'b1);
      rd = 8'($urandom);
      send_frame(1, rd, 1'($urandom_range(0, 1)), 2'b11, 32, 1'b1);
      rd = 8'($urandom);
      send_frame(2, rd, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 40, 1'b1);
    end
    rnd_ready = 1'b0;
    #3;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b1;
    line(0, 1'b1, 16);
    check_drain(0, "rnd a");
    check_drain(1, "rnd b");
    check_drain(2, "rnd c");

    // Fill to capacity, overflow by one, then drain and clear
    ready_a = 1'b0;
    for (int i = 0; i < 17; i++) begin
      send_frame(0, 8'(i), 1'b0, 2'b11, 32, i < 16);
      if (i == 15) begin
        chk("full level", level_a, 16);
        chk("full no ovr", ovr_a, 0);
      end
    end
    chk("ovr level", level_a, 16);
    chk("ovr flag", ovr_a, 1);
    chk("ovr head", data_a, 8'h00);
    ready_a = 1'b1;
    line(0, 1'b1, 24);
    chk("ovr sticky", ovr_a, 1);
    chk("ovr drained level", level_a, 0);
    check_drain(0, "ovr");
    clr_a = 1'b1;
    line(0, 1'b1, 1);
    clr_a = 1'b0;
    chk("ovr cleared", ovr_a, 0);

    // Short glitch, then reset in mid-character with the line held low
    line(0, 1'b0, 5);
    line(0, 1'b1, 48);
    chk("glitch count", got_a.size(), 0);
    chk("glitch level", level_a, 0);
    line(0, 1'b0, 16);
    line(0, 1'b1, 16);
    line(0, 1'b0, 8);
    rst_n = 1'b0;
    line(0, 1'b0, 3);
    rst_n = 1'b1;
    line(0, 1'b0, 48);
    chk("mid rst valid", valid_a, 0);
    chk("mid rst level", level_a, 0);
    chk("mid rst data", data_a, 0);
    chk("mid rst count", got_a.size(), 0);
    line(0, 1'b1, 32);
    send_frame(0, 8'h55, 1'b0, 2'b11, 32, 1'b1);
    chk("post rst entry", got_a[0], 10'h055);
    check_drain(0, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
